// File: rtl/grf_hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module   : grf_hazard_scoreboard_if
//  Brief    : D-stage hazard query bundle between the pipeline and the GRF
//             hazard scoreboard. The pipeline side is master and the
//             scoreboard side is slave.
//  Revision : 1.0 - initial release
// ============================================================================
interface grf_hazard_scoreboard_if #(
    parameter int ADDR_W = 5,
    parameter int TNEW_W = 2
);
    logic                     hold;
    logic                     d_valid;
    logic [ADDR_W-1:0]        d_rs;
    logic                     d_rs_used;
    logic [TNEW_W-1:0]        d_tuse_rs;
    logic [ADDR_W-1:0]        d_rt;
    logic                     d_rt_used;
    logic [TNEW_W-1:0]        d_tuse_rt;
    logic [ADDR_W-1:0]        d_dst;
    logic                     d_dst_we;
    logic [TNEW_W-1:0]        d_tnew;
    logic                     stall;
    logic [1:0]               fwd_rs_sel;
    logic [1:0]               fwd_rt_sel;
    logic [(1<<ADDR_W)-1:0]   busy;

    modport master (
        output hold, d_valid, d_rs, d_rs_used, d_tuse_rs, d_rt, d_rt_used,
               d_tuse_rt, d_dst, d_dst_we, d_tnew,
        input  stall, fwd_rs_sel, fwd_rt_sel, busy
    );

    modport slave (
        input  hold, d_valid, d_rs, d_rs_used, d_tuse_rs, d_rt, d_rt_used,
               d_tuse_rt, d_dst, d_dst_we, d_tnew,
        output stall, fwd_rs_sel, fwd_rt_sel, busy
    );
endinterface
`default_nettype wire

// File: rtl/grf_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : grf_hazard_scoreboard
//  Brief    : Tracks the GRF writers in flight in E/M/W together with their
//             remaining Tnew, and resolves the D-stage sources against them
//             to produce the stall, the forward selects and the busy vector.
//  Revision : 1.0 - initial release
// ============================================================================
module grf_hazard_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int TNEW_W = 2
) (
    input  wire logic             clk,
    input  wire logic             reset,
    grf_hazard_scoreboard_if.slave sb
);
    // Stage index: 0 = E, 1 = M, 2 = W (lower index is the younger stage)
    localparam int c_NSTAGE = 3;
    localparam int c_NREG   = 1 << ADDR_W;

    logic              r_valid [c_NSTAGE];
    logic [ADDR_W-1:0] r_dst   [c_NSTAGE];
    logic [TNEW_W-1:0] r_tnew  [c_NSTAGE];

    logic [2:0]        w_rs_res;
    logic [2:0]        w_rt_res;
    logic              w_stall;
    logic              w_e_valid;
    logic [c_NREG-1:0] w_busy;

    // Saturating decrement applied as an entry advances one stage
    function automatic logic [TNEW_W-1:0] f_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

    // Youngest matching writer for one source; returns {stall, sel[1:0]}
    function automatic logic [2:0] f_resolve(
        input logic [ADDR_W-1:0] src,
        input logic              used,
        input logic [TNEW_W-1:0] tuse
    );
        logic              hit;
        logic [TNEW_W-1:0] tnew;
        logic [1:0]        stage;
        logic [1:0]        sel;
        hit   = 1'b0;
        tnew  = '0;
        stage = 2'd0;
        sel   = 2'd0;
        // Walk oldest to youngest so the youngest match overwrites the rest
        for (int s = c_NSTAGE - 1; s >= 0; s--) begin
            if (used && (src != '0) && r_valid[s] && (r_dst[s] == src)) begin
                hit   = 1'b1;
                tnew  = r_tnew[s];
                stage = 2'(s);
            end
        end
        // A ready result in W is already visible through the GRF write-through
        if (hit && (tnew == '0)) begin
            case (stage)
                2'd0:    sel = 2'd1;
                2'd1:    sel = 2'd2;
                default: sel = 2'd0;
            endcase
        end
        return {hit && (tnew > tuse), sel};
    endfunction

    // Hazard resolution for both sources against the registered entries
    always_comb begin
        w_rs_res  = f_resolve(sb.d_rs, sb.d_rs_used, sb.d_tuse_rs);
        w_rt_res  = f_resolve(sb.d_rt, sb.d_rt_used, sb.d_tuse_rt);
        w_stall   = sb.d_valid & (w_rs_res[2] | w_rt_res[2]);
        w_e_valid = sb.d_valid & ~w_stall & sb.d_dst_we & (sb.d_dst != '0);
    end

    // Busy vector: one-hot destination of every tracked writer
    always_comb begin
        w_busy = '0;
        for (int s = 0; s < c_NSTAGE; s++) begin
            if (r_valid[s]) begin
                w_busy[r_dst[s]] = 1'b1;
            end
        end
    end

    // Entry pipeline: advance E->M->W with Tnew countdown unless frozen
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '{default: 1'b0};
            r_dst   <= '{default: '0};
            r_tnew  <= '{default: '0};
        end else if (!sb.hold) begin
            for (int s = 1; s < c_NSTAGE; s++) begin
                r_valid[s] <= r_valid[s-1];
                r_dst[s]   <= r_dst[s-1];
                r_tnew[s]  <= f_dec(r_tnew[s-1]);
            end
            r_valid[0] <= w_e_valid;
            r_dst[0]   <= sb.d_dst;
            r_tnew[0]  <= sb.d_tnew;
        end
    end

    assign sb.stall      = w_stall;
    assign sb.fwd_rs_sel = sb.d_valid ? w_rs_res[1:0] : 2'd0;
    assign sb.fwd_rt_sel = sb.d_valid ? w_rt_res[1:0] : 2'd0;
    assign sb.busy       = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_grf_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_grf_hazard_scoreboard
//  Brief    : Self-checking bench for grf_hazard_scoreboard: directed
//             scenarios plus randomized traffic against a queue-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_grf_hazard_scoreboard;
    localparam int ADDR_W = 5;
    localparam int TNEW_W = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    grf_hazard_scoreboard_if #(.ADDR_W(ADDR_W), .TNEW_W(TNEW_W)) sb_if ();

    grf_hazard_scoreboard #(.ADDR_W(ADDR_W), .TNEW_W(TNEW_W)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if.slave)
    );

    always #5 clk = ~clk;

    // Model: in-flight writers, youngest first; dst 0 means "no writer"
    typedef struct {
        logic [4:0] dst;
        logic [1:0] tnew;
    } wr_t;
    wr_t q[$];

    task automatic model_clear();
        wr_t e;
        e.dst  = 5'd0;
        e.tnew = 2'd0;
        q.delete();
        for (int i = 0; i < 3; i++) q.push_back(e);
    endtask

    // {stall, sel} for one source: the first (youngest) writer of src decides
    function automatic logic [2:0] model_src(input logic [4:0] src, input logic used,
                                             input logic [1:0] tuse);
        logic [2:0] r;
        logic       found;
        r     = 3'd0;
        found = 1'b0;
        if (sb_if.d_valid && used && src != 5'd0) begin
            for (int i = 0; i < 3; i++) begin
                if (!found && q[i].dst == src) begin
                    found = 1'b1;
                    r[2]  = (q[i].tnew > tuse);
                    if (q[i].tnew == 2'd0 && i < 2) r[1:0] = 2'(i + 1);
                end
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        b = 32'd0;
        for (int i = 0; i < 3; i++) if (q[i].dst != 5'd0) b[q[i].dst] = 1'b1;
        return b;
    endfunction

    // One clock edge; the model follows the inputs present at that edge
    task automatic tick();
        logic [2:0] a;
        logic [2:0] b;
        logic       st;
        wr_t        e;
        a  = model_src(sb_if.d_rs, sb_if.d_rs_used, sb_if.d_tuse_rs);
        b  = model_src(sb_if.d_rt, sb_if.d_rt_used, sb_if.d_tuse_rt);
        st = a[2] | b[2];
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else if (!sb_if.hold) begin
            for (int i = 0; i < 3; i++) q[i].tnew = (q[i].tnew == 2'd0) ? 2'd0 : q[i].tnew - 2'd1;
            e.dst  = (sb_if.d_valid && !st && sb_if.d_dst_we) ? sb_if.d_dst : 5'd0;
            e.tnew = sb_if.d_tnew;
            q.push_front(e);
            void'(q.pop_back());
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic ru, input logic [1:0] tr,
                         input logic [4:0] rt, input logic tu, input logic [1:0] tt,
                         input logic [4:0] dst, input logic we, input logic [1:0] tn);
        sb_if.d_valid   = v;
        sb_if.d_rs      = rs;
        sb_if.d_rs_used = ru;
        sb_if.d_tuse_rs = tr;
        sb_if.d_rt      = rt;
        sb_if.d_rt_used = tu;
        sb_if.d_tuse_rt = tt;
        sb_if.d_dst     = dst;
        sb_if.d_dst_we  = we;
        sb_if.d_tnew    = tn;
        #1;
    endtask

    task automatic flush();
        drive(1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        sb_if.hold = 1'b0;
        reset = 1'b1;
        model_clear();
        drive(1'b1, 5'd8, 1'b1, 2'd0, 5'd9, 1'b1, 2'd0, 5'd10, 1'b1, 2'd2);
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (sb_if.stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b want 0", sb_if.stall); end
        n_checks++; if (sb_if.fwd_rs_sel !== 2'd0) begin n_errors++; $display("FAIL reset_rs_sel: got %0d want 0", sb_if.fwd_rs_sel); end
        n_checks++; if (sb_if.fwd_rt_sel !== 2'd0) begin n_errors++; $display("FAIL reset_rt_sel: got %0d want 0", sb_if.fwd_rt_sel); end
        n_checks++; if (sb_if.busy !== 32'd0) begin n_errors++; $display("FAIL reset_busy: got %h want 0", sb_if.busy); end
        tick();
        n_checks++; if (sb_if.busy !== 32'h0000_0400) begin n_errors++; $display("FAIL first_issue_busy: got %h want 00000400", sb_if.busy); end
    endtask

    task automatic test_load_use();
        flush();
        drive(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd8, 1'b1, 2'd2);
        tick();
        drive(1'b1, 5'd8, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 5'd9, 1'b1, 2'd1);
        n_checks++; if (sb_if.stall !== 1'b1) begin n_errors++; $display("FAIL load_use_stall: got %b want 1", sb_if.stall); end
        n_checks++; if (sb_if.busy !== 32'h0000_0100) begin n_errors++; $display("FAIL load_use_busy: got %h want 00000100", sb_if.busy); end
        tick();
        n_checks++; if (sb_if.stall !== 1'b0) begin n_errors++; $display("FAIL load_use_release: got %b want 0", sb_if.stall); end
        n_checks++; if (sb_if.fwd_rs_sel !== 2'd0) begin n_errors++; $display("FAIL load_use_sel: got %0d want 0", sb_if.fwd_rs_sel); end
        tick();
    endtask

    task automatic test_branch_fwd();
        flush();
        drive(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd9, 1'b1, 2'd1);
        tick();
        drive(1'b1, 5'd9, 1'b1, 2'd0, 5'd9, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0);
        n_checks++; if (sb_if.stall !== 1'b1) begin n_errors++; $display("FAIL branch_stall: got %b want 1", sb_if.stall); end
        tick();
        n_checks++; if (sb_if.stall !== 1'b0) begin n_errors++; $display("FAIL branch_release: got %b want 0", sb_if.stall); end
        n_checks++; if (sb_if.fwd_rs_sel !== 2'd2) begin n_errors++; $display("FAIL branch_rs_sel_m: got %0d want 2", sb_if.fwd_rs_sel); end
        n_checks++; if (sb_if.fwd_rt_sel !== 2'd2) begin n_errors++; $display("FAIL branch_rt_sel_m: got %0d want 2", sb_if.fwd_rt_sel); end
        tick();
        n_checks++; if (sb_if.fwd_rs_sel !== 2'd0) begin n_errors++; $display("FAIL branch_rs_sel_w: got %0d want 0", sb_if.fwd_rs_sel); end
        n_checks++; if (sb_if.stall !== 1'b0) begin n_errors++; $display("FAIL branch_w_stall: got %b want 0", sb_if.stall); end
    endtask

    task automatic test_zero_reg();
        flush();
        drive(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b1, 2'd2);
        tick();
        drive(1'b1, 5'd0, 1'b1, 2'd0, 5'd0, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0);
        for (int c = 0; c < 2; c++) begin
            n_checks++; if (sb_if.stall !== 1'b0) begin n_errors++; $display("FAIL zero_stall[%0d]: got %b want 0", c, sb_if.stall); end
            n_checks++; if (sb_if.fwd_rs_sel !== 2'd0 || sb_if.fwd_rt_sel !== 2'd0) begin
                n_errors++; $display("FAIL zero_sel[%0d]: got %0d/%0d want 0/0", c, sb_if.fwd_rs_sel, sb_if.fwd_rt_sel);
            end
            n_checks++; if (sb_if.busy !== 32'd0) begin n_errors++; $display("FAIL zero_busy[%0d]: got %h want 0", c, sb_if.busy); end
            tick();
        end
    endtask

    task automatic test_e_priority();
        flush();
        drive(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd5, 1'b1, 2'd0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd5, 1'b1, 2'd0);
        tick();
        drive(1'b1, 5'd5, 1'b1, 2'd0, 5'd5, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0);
        n_checks++; if (sb_if.fwd_rs_sel !== 2'd1) begin n_errors++; $display("FAIL prio_rs_sel: got %0d want 1", sb_if.fwd_rs_sel); end
        n_checks++; if (sb_if.fwd_rt_sel !== 2'd1) begin n_errors++; $display("FAIL prio_rt_sel: got %0d want 1", sb_if.fwd_rt_sel); end
        n_checks++; if (sb_if.stall !== 1'b0) begin n_errors++; $display("FAIL prio_stall: got %b want 0", sb_if.stall); end
    endtask

    task automatic test_hold();
        flush();
        drive(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd8, 1'b1, 2'd2);
        tick();
        sb_if.hold = 1'b1;
        drive(1'b1, 5'd8, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 5'd9, 1'b1, 2'd1);
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (sb_if.stall !== 1'b1) begin n_errors++; $display("FAIL hold_stall[%0d]: got %b want 1", c, sb_if.stall); end
            n_checks++; if (sb_if.busy !== 32'h0000_0100) begin n_errors++; $display("FAIL hold_busy[%0d]: got %h want 00000100", c, sb_if.busy); end
            tick();
        end
        sb_if.hold = 1'b0;
        #1;
        n_checks++; if (sb_if.stall !== 1'b1) begin n_errors++; $display("FAIL hold_drop_stall: got %b want 1", sb_if.stall); end
        tick();
        n_checks++; if (sb_if.stall !== 1'b0) begin n_errors++; $display("FAIL hold_after_stall: got %b want 0", sb_if.stall); end
        n_checks++; if (sb_if.fwd_rs_sel !== 2'd0) begin n_errors++; $display("FAIL hold_after_sel: got %0d want 0", sb_if.fwd_rs_sel); end
    endtask

    task automatic test_reset_mid_stall();
        flush();
        drive(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd8, 1'b1, 2'd2);
        tick();
        drive(1'b1, 5'd8, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 5'd9, 1'b1, 2'd1);
        n_checks++; if (sb_if.stall !== 1'b1) begin n_errors++; $display("FAIL rst_mid_pre: got %b want 1", sb_if.stall); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (sb_if.stall !== 1'b0) begin n_errors++; $display("FAIL rst_mid_stall: got %b want 0", sb_if.stall); end
        n_checks++; if (sb_if.busy !== 32'd0) begin n_errors++; $display("FAIL rst_mid_busy: got %h want 0", sb_if.busy); end
        n_checks++; if (sb_if.fwd_rs_sel !== 2'd0) begin n_errors++; $display("FAIL rst_mid_sel: got %0d want 0", sb_if.fwd_rs_sel); end
    endtask

    task automatic test_random();
        logic [2:0] a;
        logic [2:0] b;
        logic [31:0] eb;
        for (int n = 0; n < 600; n++) begin
            reset      = ($urandom_range(0, 49) == 0);
            sb_if.hold = ($urandom_range(0, 9) == 0);
            drive(($urandom_range(0, 5) != 0),
                  5'($urandom_range(0, 7)), 1'($urandom), 2'($urandom_range(0, 2)),
                  5'($urandom_range(0, 7)), 1'($urandom), 2'($urandom_range(0, 2)),
                  5'($urandom_range(0, 7)), 1'($urandom), 2'($urandom));
            a  = model_src(sb_if.d_rs, sb_if.d_rs_used, sb_if.d_tuse_rs);
            b  = model_src(sb_if.d_rt, sb_if.d_rt_used, sb_if.d_tuse_rt);
            eb = model_busy();
            n_checks++; if (sb_if.stall !== (a[2] | b[2])) begin n_errors++; $display("FAIL rnd_stall[%0d]: got %b want %b", n, sb_if.stall, a[2] | b[2]); end
            n_checks++; if (sb_if.fwd_rs_sel !== a[1:0]) begin n_errors++; $display("FAIL rnd_rs_sel[%0d]: got %0d want %0d", n, sb_if.fwd_rs_sel, a[1:0]); end
            n_checks++; if (sb_if.fwd_rt_sel !== b[1:0]) begin n_errors++; $display("FAIL rnd_rt_sel[%0d]: got %0d want %0d", n, sb_if.fwd_rt_sel, b[1:0]); end
            n_checks++; if (sb_if.busy !== eb) begin n_errors++; $display("FAIL rnd_busy[%0d]: got %h want %h", n, sb_if.busy, eb); end
            tick();
        end
        reset      = 1'b0;
        sb_if.hold = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_fwd();
        test_zero_reg();
        test_e_priority();
        test_hold();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
